// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard and stall controller for a 5-stage MIPS pipeline. It produces the
// F/D stall, the D/E flush and the forwarding selects for the D and E stages.
// It also times the multi-cycle MULT/DIV unit with a busy countdown, and it
// keeps a saturating count of stalled cycles.
//
// Parameters
//   MD_LATENCY : cycles the MULT/DIV unit is occupied after issue (>= 1)
//   CNT_W      : width of StallCount_o
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   RsD_i, RtD_i                  D-stage source registers
//   BranchD_i, MdUseD_i           D is beq/bne, D uses mult/div/hi/lo
//   RsE_i, RtE_i, WriteRegE_i     E-stage sources / destination
//   RegWriteE_i, MemtoRegE_i      E-stage write enable / load
//   MdStartE_i                    mult/div issuing from E
//   WriteRegM_i, RegWriteM_i,
//   MemtoRegM_i                   M-stage destination / write / load
//   WriteRegW_i, RegWriteW_i      W-stage destination / write
//   StallF_o, StallD_o, FlushE_o  hold PC, hold F/D, bubble D/E
//   ForwardAD_o, ForwardBD_o      D compare operand takes ALUOutM
//   ForwardAE_o, ForwardBE_o      E operand: 00 regfile, 01 ResultW, 10 ALUOutM
//   StallCause_o                  {md, wb, branch, load}
//   MdBusy_o                      MULT/DIV countdown nonzero
//   StallCount_o                  saturating stalled-cycle count
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       RsD_i,
    input  logic [4:0]       RtD_i,
    input  logic             BranchD_i,
    input  logic             MdUseD_i,
    input  logic [4:0]       RsE_i,
    input  logic [4:0]       RtE_i,
    input  logic [4:0]       WriteRegE_i,
    input  logic             RegWriteE_i,
    input  logic             MemtoRegE_i,
    input  logic             MdStartE_i,
    input  logic [4:0]       WriteRegM_i,
    input  logic             RegWriteM_i,
    input  logic             MemtoRegM_i,
    input  logic [4:0]       WriteRegW_i,
    input  logic             RegWriteW_i,
    output logic             StallF_o,
    output logic             StallD_o,
    output logic             FlushE_o,
    output logic             ForwardAD_o,
    output logic             ForwardBD_o,
    output logic [1:0]       ForwardAE_o,
    output logic [1:0]       ForwardBE_o,
    output logic [3:0]       StallCause_o,
    output logic             MdBusy_o,
    output logic [CNT_W-1:0] StallCount_o
);

    localparam int              MD_W    = $clog2(MD_LATENCY + 1);
    localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LATENCY - 1);

    // Register 0 is hardwired to zero, so it never produces a dependency.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (dst != 5'd0) && (dst == src);
    endfunction

    logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;

    logic load_stall;
    logic branch_stall;
    logic wb_stall;
    logic md_stall;
    logic stall;

    // ------------------------------------------------------------------
    // Forwarding
    // ------------------------------------------------------------------
    always_comb begin
        ForwardAE_o = 2'b00;
        if (RegWriteM_i && reg_match(RsE_i, WriteRegM_i)) begin
            ForwardAE_o = 2'b10;
        end else if (RegWriteW_i && reg_match(RsE_i, WriteRegW_i)) begin
            ForwardAE_o = 2'b01;
        end

        ForwardBE_o = 2'b00;
        if (RegWriteM_i && reg_match(RtE_i, WriteRegM_i)) begin
            ForwardBE_o = 2'b10;
        end else if (RegWriteW_i && reg_match(RtE_i, WriteRegW_i)) begin
            ForwardBE_o = 2'b01;
        end
    end

    assign ForwardAD_o = RegWriteM_i && reg_match(RsD_i, WriteRegM_i);
    assign ForwardBD_o = RegWriteM_i && reg_match(RtD_i, WriteRegM_i);

    // ------------------------------------------------------------------
    // Stall terms
    // ------------------------------------------------------------------
    assign load_stall = MemtoRegE_i &&
                        (reg_match(RsD_i, WriteRegE_i) || reg_match(RtD_i, WriteRegE_i));

    assign branch_stall = BranchD_i &&
                          ((RegWriteE_i &&
                            (reg_match(RsD_i, WriteRegE_i) || reg_match(RtD_i, WriteRegE_i))) ||
                           (MemtoRegM_i &&
                            (reg_match(RsD_i, WriteRegM_i) || reg_match(RtD_i, WriteRegM_i))));

    // The register file writes on the clock edge, so D would read the stale
    // value during the write cycle; hold D one cycle instead.
    assign wb_stall = RegWriteW_i &&
                      (reg_match(RsD_i, WriteRegW_i) || reg_match(RtD_i, WriteRegW_i));

    assign md_stall = MdUseD_i && (MdBusy_o || MdStartE_i);

    assign stall        = load_stall | branch_stall | wb_stall | md_stall;
    assign StallF_o     = stall;
    assign StallD_o     = stall;
    assign FlushE_o     = stall;
    assign StallCause_o = {md_stall, wb_stall, branch_stall, load_stall};

    // ------------------------------------------------------------------
    // MULT/DIV countdown. The issue cycle itself is covered by MdStartE_i,
    // so the counter only has to cover the remaining MD_LATENCY-1 cycles.
    // A start while busy simply reloads.
    // ------------------------------------------------------------------
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (MdStartE_i) begin
            md_cnt_d = MD_LOAD;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MD_W'(1);
        end
    end

    assign MdBusy_o = (md_cnt_q != '0);

    // ------------------------------------------------------------------
    // Saturating stall counter: one increment per stalled cycle, however
    // many causes are active.
    // ------------------------------------------------------------------
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    assign StallCount_o = stall_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt_q      <= '0;
            stall_count_q <= '0;
        end else begin
            md_cnt_q      <= md_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and stall controller for the 5-stage MIPS pipeline. It decides stall, flush and forward-select for the F/D/E stages. Its inputs are the register-file write port (W stage), the M-stage ALU result path, and the D-stage branch comparator. It sequences a multi-cycle MULT/DIV unit with a busy countdown and keeps a saturating stall-cycle counter for performance checks.

## Interface
Parameters:
- MD_LATENCY, 32, cycles the MULT/DIV unit occupies after issue (≥1)
- CNT_W, 16, width of StallCount

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous active-low reset
- RsD, RtD  in  5  source register fields of instruction in D
- BranchD  in  1  D instruction is beq/bne (compares in D)
- MdUseD  in  1  D instruction is mult/div/mfhi/mflo
- RsE, RtE  in  5  source fields in E
- WriteRegE  in  5  destination in E; RegWriteE, MemtoRegE in 1
- MdStartE  in  1  mult/div issuing from E this cycle
- WriteRegM  in  5  destination in M; RegWriteM, MemtoRegM in 1
- WriteRegW  in  5  destination in W; RegWriteW in 1
- StallF, StallD, FlushE  out  1  hold PC, hold F/D register, bubble D/E register
- ForwardAD, ForwardBD  out  1  select ALUOutM for D-stage compare operand A/B
- ForwardAE, ForwardBE  out  2  E operand select: 00 reg file, 01 ResultW, 10 ALUOutM
- StallCause  out  4  {md, wb, branch, load} stall terms, one-hot or multi-hot
- MdBusy  out  1  MULT/DIV countdown nonzero
- StallCount  out  CNT_W  saturating count of stalled cycles

## Operation
"match(x,r)" means r != 0 and r == x. Register 0 never triggers forward or stall.

Forwarding (combinational):
- ForwardAE = 10 if RegWriteM and match(RsE,WriteRegM); else 01 if RegWriteW and match(RsE,WriteRegW); else 00. M has priority over W. ForwardBE is the same with RtE.
- ForwardAD = RegWriteM and match(RsD,WriteRegM). ForwardBD is the same with RtD.

Stall terms (combinational):
- load: MemtoRegE and (match(RsD,WriteRegE) or match(RtD,WriteRegE)).
- branch: BranchD and [(RegWriteE and match(RsD|RtD,WriteRegE)) or (MemtoRegM and match(RsD|RtD,WriteRegM))].
- wb: RegWriteW and (match(RsD,WriteRegW) or match(RtD,WriteRegW)). The register file writes on posedge, so D reads the old value in the write cycle.
- md: MdUseD and (MdBusy or MdStartE).
- StallF = StallD = FlushE = OR of all terms. StallCause gives each term individually.

MULT/DIV countdown (MdCnt, internal, width clog2(MD_LATENCY+1)):
- On MdStartE, load MD_LATENCY-1, which overrides the decrement. Otherwise decrement while nonzero. MdBusy = (MdCnt != 0).
- MD_LATENCY = 1 means MdBusy never asserts; md stalls only on MdStartE.
- MdStartE while MdBusy is a protocol error. It reloads the counter.

StallCount increments on each posedge where StallD = 1. It holds at all-ones once it reaches all-ones.

## Timing
- Forward, stall and StallCause outputs are combinational from inputs and MdCnt, with zero latency.
- MdBusy rises the cycle after a MdStartE edge and stays high MD_LATENCY-1 cycles. A dependent MdUseD instruction stalls MD_LATENCY cycles in total, counting the MdStartE cycle.
- Reset (rst_n low, asynchronous): MdCnt = 0, MdBusy = 0, StallCount = 0 immediately. During reset the combinational outputs still follow their inputs. Reset during a countdown aborts it; the next MdUseD after release does not stall unless MdStartE is high.
- Simultaneous load and branch terms assert one stall cycle, not two. The count increments by 1 per stalled cycle regardless of how many causes are active.

## Test plan
- E forward priority: RsE=5, RegWriteM=1/WriteRegM=5, RegWriteW=1/WriteRegW=5 -> ForwardAE=10. Drop RegWriteM -> 01. WriteRegM=WriteRegW=0 -> 00.
- Load-use: MemtoRegE=1, WriteRegE=8, RtD=8 -> StallF=StallD=FlushE=1 and StallCause=0001 for exactly 1 cycle. RtD=0 with WriteRegE=0 -> no stall.
- Branch: BranchD=1, RsD=3, RegWriteE=1/WriteRegE=3 -> stall with cause 0010. Next cycle, RegWriteM=1/WriteRegM=3, MemtoRegM=0 -> no stall and ForwardAD=1.
- Write-back: RegWriteW=1, WriteRegW=9, RsD=9 -> 1-cycle stall with cause 0100. The next cycle without the match -> no stall.
- MULT/DIV with MD_LATENCY=4: MdStartE pulse at cycle 0 with MdUseD held -> stall at cycles 0-3 and MdBusy high at cycles 1-3. StallCount goes from 0 to 4. Assert rst_n low at cycle 2 -> MdBusy=0 and StallCount=0 at once.
- Saturation with CNT_W=3: hold a stall 10 cycles -> StallCount stops at 7.
